embertrail_dmem_arbiter: RTL and testbench
==========================================

# embertrail_dmem_arbiter

Shares the single-ported data memory between the two instruction slots of the Embertrail dual-issue core. Each slot presents one load or store per bundle. The arbiter latches both requests, serialises them in program order (slot 1 then slot 2), and returns read data. It signals bundle completion so the control unit can hold its stage counter.

## Interface
- ADDR_W, 16, data memory address width
- DATA_W, 16, data word width
- iClock  in  1  clock, all state updates on rising edge
- iReset  in  1  synchronous, active-high reset
- iReq1  in  1  slot 1 access request (level), held until oDone
- iRW1  in  1  slot 1 direction: 1 = store, 0 = load
- iAddr1  in  ADDR_W  slot 1 address
- iWData1  in  DATA_W  slot 1 store data
- iReq2, iRW2, iAddr2, iWData2  in  1/1/ADDR_W/DATA_W  slot 2 equivalents
- oRData1, oRData2  out  DATA_W  load results, registered
- oDone  out  1  one-cycle pulse: bundle complete, oRDataN valid
- oBusy  out  1  high while a bundle is in progress (state != IDLE)
- oConflictCount  out  8  saturating count of bundles with both slots requesting
- oMemEn  out  1  memory port enable
- oMemWE  out  1  memory write enable (valid only with oMemEn)
- oMemAddr  out  ADDR_W  memory address
- oMemWData  out  DATA_W  memory write data
- iMemRData  in  DATA_W  memory read data, valid the cycle after a load issue

## Operation
- States: IDLE, ISSUE1, ISSUE2, FINISH.
- IDLE, oDone=0, (iReq1|iReq2):
  - Latch all eight request inputs into internal registers.
  - Go to ISSUE1 if iReq1, else ISSUE2.
  - If both requests are high, increment oConflictCount, saturating at 255.
- IDLE, oDone=1: requests are ignored, because held requests from the finished bundle are still high.
- ISSUE1:
  - Drive oMemEn=1, oMemWE=latched RW1, oMemAddr=latched Addr1, oMemWData=latched WData1.
  - Next state is ISSUE2 if slot 2 was latched, else FINISH.
- ISSUE2:
  - Drive the memory port from the slot 2 latches.
  - If slot 1 issued a load, capture iMemRData into oRData1.
  - Next state is FINISH.
- FINISH:
  - oMemEn=0.
  - Capture iMemRData into the result register of the last-issued slot if that slot was a load.
  - Set the oDone register; next state is IDLE.
- Outside ISSUE states: oMemEn=0, oMemWE=0, oMemAddr and oMemWData hold 0.
- A slot that did not request, or that stored, keeps its previous oRData value.
- Forwarding: if slot 1 stores and slot 2 loads the same address, oRData2 = latched WData1, not iMemRData.
- Same-address double store: slot 2 issues second, so memory ends with WData2.
- Reset, including mid-bundle: state=IDLE.
  - All outputs 0: oRData1/2, oDone, oBusy, oConflictCount, oMemEn, oMemWE, oMemAddr, oMemWData.
  - Any partially issued bundle is abandoned; its store is not replayed.

## Timing
- All outputs are registered or decoded from state only; there is no combinational path from iReq*/iAddr* to the memory port.
- Dual bundle, request seen in cycle 0: ISSUE1 c1, ISSUE2 c2, FINISH c3, oDone c4. Latency is 4 cycles.
- Single-slot bundle: ISSUE c1, FINISH c2, oDone c3. Latency is 3 cycles.
- oBusy is high from c1 through FINISH inclusive.
- The earliest next bundle is accepted the cycle after oDone, provided the requests are re-asserted.
- Request inputs may change freely after c0; only the latched copies are used.

## Test plan
- Reset, then idle 5 cycles -> all outputs 0, oMemEn never asserted.
- Slot 1 load only, Addr1=0x0010, memory[0x10]=0xBEEF:
  - oMemEn=1/oMemWE=0/oMemAddr=0x0010 at c1.
  - oDone and oRData1=0xBEEF at c3; oConflictCount=0.
- Dual bundle, slot 1 store 0x1234 @0x0020, slot 2 load @0x0021 (memory=0x5555):
  - Write at c1, read at c2.
  - oDone at c4 with oRData2=0x5555; oConflictCount=1.
- Slot 1 store 0xCAFE @0x0030, slot 2 load @0x0030 -> oRData2=0xCAFE at oDone, even with a stale memory model.
- Both store to @0x0040 (0x1111, then 0x2222) -> memory[0x40]=0x2222. Requests held high through oDone -> no second bundle starts in the oDone cycle.
- Assert iReset during ISSUE2 of a dual bundle -> next cycle state IDLE, oMemEn=0, oBusy=0, no oDone. Separately, run 300 dual bundles -> oConflictCount saturates at 255.

Source files
------------

// File: rtl/embertrail_dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// embertrail_dmem_arbiter_if : slot request and data-memory port bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface embertrail_dmem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              iReq1;
   logic              iRW1;
   logic [ADDR_W-1:0] iAddr1;
   logic [DATA_W-1:0] iWData1;
   logic              iReq2;
   logic              iRW2;
   logic [ADDR_W-1:0] iAddr2;
   logic [DATA_W-1:0] iWData2;
   logic [DATA_W-1:0] oRData1;
   logic [DATA_W-1:0] oRData2;
   logic              oDone;
   logic              oBusy;
   logic [7:0]        oConflictCount;
   logic              oMemEn;
   logic              oMemWE;
   logic [ADDR_W-1:0] oMemAddr;
   logic [DATA_W-1:0] oMemWData;
   logic [DATA_W-1:0] iMemRData;

   // Core side and memory side seen from outside the arbiter.
   modport master (
      output iReq1, iRW1, iAddr1, iWData1,
      output iReq2, iRW2, iAddr2, iWData2,
      output iMemRData,
      input  oRData1, oRData2, oDone, oBusy, oConflictCount,
      input  oMemEn, oMemWE, oMemAddr, oMemWData
   );

   modport slave (
      input  iReq1, iRW1, iAddr1, iWData1,
      input  iReq2, iRW2, iAddr2, iWData2,
      input  iMemRData,
      output oRData1, oRData2, oDone, oBusy, oConflictCount,
      output oMemEn, oMemWE, oMemAddr, oMemWData
   );
endinterface

`default_nettype wire

// File: rtl/embertrail_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// embertrail_dmem_arbiter : serialises two slot accesses onto one data memory
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module embertrail_dmem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  wire logic                    iClock,
   input  wire logic                    iReset,
   embertrail_dmem_arbiter_if.slave     bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE1 = 2'd1,
      ST_ISSUE2 = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              req1_q, req1_d, rw1_q, rw1_d;
   logic              req2_q, req2_d, rw2_q, rw2_d;
   logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
   logic [DATA_W-1:0] wdata1_q, wdata1_d, wdata2_q, wdata2_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d;
   logic              done_q, done_d, busy_q, busy_d;
   logic [7:0]        conflict_q, conflict_d;
   logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   // The memory port is registered one state ahead, so it never sees a
   // combinational path from the request inputs.
   always_comb begin
      state_d     = state_q;
      req1_d      = req1_q;
      rw1_d       = rw1_q;
      addr1_d     = addr1_q;
      wdata1_d    = wdata1_q;
      req2_d      = req2_q;
      rw2_d       = rw2_q;
      addr2_d     = addr2_q;
      wdata2_d    = wdata2_q;
      rdata1_d    = rdata1_q;
      rdata2_d    = rdata2_q;
      conflict_d  = conflict_q;
      done_d      = 1'b0;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;

      case (state_q)
         ST_IDLE: begin
            // Requests are still held in the oDone cycle; ignore them there.
            if (!done_q && (bus.iReq1 || bus.iReq2)) begin
               req1_d   = bus.iReq1;
               rw1_d    = bus.iRW1;
               addr1_d  = bus.iAddr1;
               wdata1_d = bus.iWData1;
               req2_d   = bus.iReq2;
               rw2_d    = bus.iRW2;
               addr2_d  = bus.iAddr2;
               wdata2_d = bus.iWData2;
               if (bus.iReq1 && bus.iReq2 && conflict_q != 8'hFF) begin
                  conflict_d = conflict_q + 8'd1;
               end
               mem_en_d = 1'b1;
               if (bus.iReq1) begin
                  state_d     = ST_ISSUE1;
                  mem_we_d    = bus.iRW1;
                  mem_addr_d  = bus.iAddr1;
                  mem_wdata_d = bus.iWData1;
               end else begin
                  state_d     = ST_ISSUE2;
                  mem_we_d    = bus.iRW2;
                  mem_addr_d  = bus.iAddr2;
                  mem_wdata_d = bus.iWData2;
               end
            end
         end
         ST_ISSUE1: begin
            if (req2_q) begin
               state_d     = ST_ISSUE2;
               mem_en_d    = 1'b1;
               mem_we_d    = rw2_q;
               mem_addr_d  = addr2_q;
               mem_wdata_d = wdata2_q;
            end else begin
               state_d = ST_FINISH;
            end
         end
         ST_ISSUE2: begin
            state_d = ST_FINISH;
            if (req1_q && !rw1_q) begin
               rdata1_d = bus.iMemRData;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            if (req2_q) begin
               if (!rw2_q) begin
                  // Slot 1 store to the same word must be visible to slot 2.
                  rdata2_d = (req1_q && rw1_q && addr1_q == addr2_q) ?
                             wdata1_q : bus.iMemRData;
               end
            end else if (req1_q && !rw1_q) begin
               rdata1_d = bus.iMemRData;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         state_q     <= ST_IDLE;
         req1_q      <= 1'b0;
         rw1_q       <= 1'b0;
         addr1_q     <= '0;
         wdata1_q    <= '0;
         req2_q      <= 1'b0;
         rw2_q       <= 1'b0;
         addr2_q     <= '0;
         wdata2_q    <= '0;
         rdata1_q    <= '0;
         rdata2_q    <= '0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         conflict_q  <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         req1_q      <= req1_d;
         rw1_q       <= rw1_d;
         addr1_q     <= addr1_d;
         wdata1_q    <= wdata1_d;
         req2_q      <= req2_d;
         rw2_q       <= rw2_d;
         addr2_q     <= addr2_d;
         wdata2_q    <= wdata2_d;
         rdata1_q    <= rdata1_d;
         rdata2_q    <= rdata2_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         conflict_q  <= conflict_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign bus.oRData1        = rdata1_q;
   assign bus.oRData2        = rdata2_q;
   assign bus.oDone          = done_q;
   assign bus.oBusy          = busy_q;
   assign bus.oConflictCount = conflict_q;
   assign bus.oMemEn         = mem_en_q;
   assign bus.oMemWE         = mem_we_q;
   assign bus.oMemAddr       = mem_addr_q;
   assign bus.oMemWData      = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_embertrail_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_embertrail_dmem_arbiter : directed and randomized bundles against a
// transaction-level memory/result model. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_embertrail_dmem_arbiter;
   localparam int AW = 16;
   localparam int DW = 16;

   logic iClock = 1'b0;
   logic iReset;
   always #5 iClock = ~iClock;

   embertrail_dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   embertrail_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .iClock (iClock),
      .iReset (iReset),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [15:0] tb_mem  [int];
   logic [15:0] ref_mem [int];
   bit          mem_stale = 1'b0;

   logic [15:0] exp_r1 = '0;
   logic [15:0] exp_r2 = '0;
   int          exp_cc = 0;

   function automatic logic [15:0] init_val(int a);
      return 16'((a * 40503) ^ 15450);
   endfunction

   function automatic logic [15:0] tb_rd(int a);
      return tb_mem.exists(a) ? tb_mem[a] : init_val(a);
   endfunction

   function automatic logic [15:0] ref_rd(int a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   // Synchronous single-port memory; read data is junk unless a load issued.
   always @(posedge iClock) begin
      if (bus.oMemEn && bus.oMemWE) begin
         if (!mem_stale) tb_mem[int'(bus.oMemAddr)] = bus.oMemWData;
         bus.iMemRData <= 16'($urandom);
      end else if (bus.oMemEn) begin
         bus.iMemRData <= tb_rd(int'(bus.oMemAddr));
      end else begin
         bus.iMemRData <= 16'($urandom);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_port(input string tag, input logic en, input logic we,
                           input logic [15:0] a, input logic [15:0] wd);
      chk({tag, "_en"},    32'(bus.oMemEn),    32'(en));
      chk({tag, "_we"},    32'(bus.oMemWE),    32'(we));
      chk({tag, "_addr"},  32'(bus.oMemAddr),  32'(a));
      chk({tag, "_wdata"}, 32'(bus.oMemWData), 32'(wd));
   endtask

   task automatic cyc();
      @(posedge iClock);
      #1;
   endtask

   // Called at a sample point; leaves requests low one cycle after oDone.
   task automatic run_bundle(input logic r1, input logic rw1, input logic [15:0] a1,
                             input logic [15:0] w1, input logic r2, input logic rw2,
                             input logic [15:0] a2, input logic [15:0] w2);
      int   lat;
      logic both;
      bus.iReq1 = r1; bus.iRW1 = rw1; bus.iAddr1 = a1; bus.iWData1 = w1;
      bus.iReq2 = r2; bus.iRW2 = rw2; bus.iAddr2 = a2; bus.iWData2 = w2;

      both = r1 && r2;
      lat  = both ? 4 : 3;
      if (both && exp_cc < 255) exp_cc++;
      if (r1) begin
         if (rw1) ref_mem[int'(a1)] = w1;
         else     exp_r1 = ref_rd(int'(a1));
      end
      if (r2) begin
         if (rw2) ref_mem[int'(a2)] = w2;
         else     exp_r2 = ref_rd(int'(a2));
      end

      for (int k = 1; k <= lat; k++) begin
         cyc();
         // Only the latched copies matter once the bundle is accepted.
         bus.iRW1 = 1'($urandom); bus.iAddr1 = 16'($urandom); bus.iWData1 = 16'($urandom);
         bus.iRW2 = 1'($urandom); bus.iAddr2 = 16'($urandom); bus.iWData2 = 16'($urandom);
         chk("done",  32'(bus.oDone), 32'(k == lat));
         chk("busy",  32'(bus.oBusy), 32'(k < lat));
         if (k == 1 && r1)          chk_port("port_s1", 1'b1, rw1, a1, w1);
         else if (k == 1)           chk_port("port_s2", 1'b1, rw2, a2, w2);
         else if (k == 2 && both)   chk_port("port_s2", 1'b1, rw2, a2, w2);
         else                       chk_port("port_idle", 1'b0, 1'b0, 16'h0, 16'h0);
         if (k == lat) begin
            chk("rdata1",   32'(bus.oRData1),        32'(exp_r1));
            chk("rdata2",   32'(bus.oRData2),        32'(exp_r2));
            chk("conflict", 32'(bus.oConflictCount), 32'(exp_cc));
         end
      end
      cyc();
      chk("no_restart_busy", 32'(bus.oBusy), 32'd0);
      chk("no_restart_done", 32'(bus.oDone), 32'd0);
      chk("no_restart_en",   32'(bus.oMemEn), 32'd0);
      bus.iReq1 = 1'b0;
      bus.iReq2 = 1'b0;
   endtask

   initial begin
      iReset = 1'b1;
      bus.iReq1 = 0; bus.iRW1 = 0; bus.iAddr1 = '0; bus.iWData1 = '0;
      bus.iReq2 = 0; bus.iRW2 = 0; bus.iAddr2 = '0; bus.iWData2 = '0;
      repeat (3) cyc();
      iReset = 1'b0;

      // Idle after reset.
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("idle_en",   32'(bus.oMemEn), 32'd0);
         chk("idle_done", 32'(bus.oDone),  32'd0);
         chk("idle_busy", 32'(bus.oBusy),  32'd0);
      end
      chk("idle_rdata1", 32'(bus.oRData1),        32'd0);
      chk("idle_rdata2", 32'(bus.oRData2),        32'd0);
      chk("idle_cc",     32'(bus.oConflictCount), 32'd0);
      chk_port("idle_port", 1'b0, 1'b0, 16'h0, 16'h0);

      // Slot 1 load only.
      tb_mem[32'h10] = 16'hBEEF; ref_mem[32'h10] = 16'hBEEF;
      run_bundle(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
      chk("single_load_val", 32'(bus.oRData1), 32'h0000BEEF);

      // Dual: store then load of a different word.
      tb_mem[32'h21] = 16'h5555; ref_mem[32'h21] = 16'h5555;
      run_bundle(1, 1, 16'h0020, 16'h1234, 1, 0, 16'h0021, 16'h0);
      chk("dual_load_val", 32'(bus.oRData2), 32'h00005555);
      chk("dual_store_mem", 32'(tb_rd(32'h20)), 32'h00001234);

      // Store-to-load forwarding with a memory that drops writes.
      mem_stale = 1'b1;
      run_bundle(1, 1, 16'h0030, 16'hCAFE, 1, 0, 16'h0030, 16'h0);
      chk("forward_val", 32'(bus.oRData2), 32'h0000CAFE);
      mem_stale = 1'b0;
      tb_mem[32'h30] = 16'hCAFE;

      // Same-address double store: slot 2 wins.
      run_bundle(1, 1, 16'h0040, 16'h1111, 1, 1, 16'h0040, 16'h2222);
      chk("dbl_store_mem", 32'(tb_rd(32'h40)), 32'h00002222);

      // Randomized bundles over a tiny address window.
      for (int n = 0; n < 40; n++) begin
         int sel;
         sel = $urandom_range(1, 3);
         run_bundle(sel[0], 1'($urandom), 16'($urandom_range(0, 7)), 16'($urandom),
                    sel[1], 1'($urandom), 16'($urandom_range(0, 7)), 16'($urandom));
      end
      for (int a = 0; a < 8; a++) chk("rand_mem", 32'(tb_rd(a)), 32'(ref_rd(a)));

      // Reset in ISSUE2 of a dual bundle.
      bus.iReq1 = 1; bus.iRW1 = 1; bus.iAddr1 = 16'h0050; bus.iWData1 = 16'h7777;
      bus.iReq2 = 1; bus.iRW2 = 0; bus.iAddr2 = 16'h0051; bus.iWData2 = 16'h0;
      cyc();
      chk_port("rst_c1", 1'b1, 1'b1, 16'h0050, 16'h7777);
      cyc();
      chk_port("rst_c2", 1'b1, 1'b0, 16'h0051, 16'h0);
      iReset = 1'b1;
      cyc();
      iReset = 1'b0;
      bus.iReq1 = 0; bus.iReq2 = 0;
      ref_mem[32'h50] = 16'h7777;
      exp_r1 = '0; exp_r2 = '0; exp_cc = 0;
      chk("rst_busy",   32'(bus.oBusy),          32'd0);
      chk("rst_done",   32'(bus.oDone),          32'd0);
      chk("rst_cc",     32'(bus.oConflictCount), 32'd0);
      chk("rst_rdata1", 32'(bus.oRData1),        32'd0);
      chk("rst_rdata2", 32'(bus.oRData2),        32'd0);
      chk_port("rst_port", 1'b0, 1'b0, 16'h0, 16'h0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("post_rst_en",   32'(bus.oMemEn), 32'd0);
         chk("post_rst_done", 32'(bus.oDone),  32'd0);
      end

      // Saturation of the conflict counter.
      for (int n = 0; n < 300; n++) begin
         run_bundle(1, 1'($urandom), 16'(16'h0100 + $urandom_range(0, 3)), 16'($urandom),
                    1, 1'($urandom), 16'(16'h0100 + $urandom_range(0, 3)), 16'($urandom));
      end
      chk("cc_saturated", 32'(bus.oConflictCount), 32'd255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL timeout observed=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
